// File: rtl/pulse_train_if.sv
// Control/status bundle for pulse_train_gen. The master side loads the train
// parameters and strikes start; the slave side reports pulse_out and progress.
interface pulse_train_if #(
    parameter int CNT_W = 16,
    parameter int TIM_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] count;
    logic [TIM_W-1:0] high_cycles;
    logic [TIM_W-1:0] low_cycles;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, abort, count, high_cycles, low_cycles,
        input  pulse_out, busy, done, remaining
    );

    modport slave (
        input  start, abort, count, high_cycles, low_cycles,
        output pulse_out, busy, done, remaining
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Programmable pulse train: N pulses, H cycles high then L cycles low each,
// with busy/done status and a count of pulses still outstanding.
module pulse_train_gen #(
    parameter int CNT_W = 16,
    parameter int TIM_W = 16
) (
    input  logic          clk,
    input  logic          resetn,
    pulse_train_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [TIM_W-1:0] timer_q, timer_d;
    logic [TIM_W-1:0] h_q, h_d;
    logic [TIM_W-1:0] l_q, l_d;

    // Zero durations are clamped to one cycle so every phase is visible.
    logic [TIM_W-1:0] h_in, l_in;
    assign h_in = (bus.high_cycles == '0) ? TIM_W'(1) : bus.high_cycles;
    assign l_in = (bus.low_cycles  == '0) ? TIM_W'(1) : bus.low_cycles;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            timer_q <= '0;
            h_q     <= '0;
            l_q     <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            timer_q <= timer_d;
            h_q     <= h_d;
            l_q     <= l_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        timer_d = timer_q;
        h_d     = h_q;
        l_d     = l_q;
        if (bus.abort) begin
            state_d = IDLE;
            pulse_d = 1'b0;
            busy_d  = 1'b0;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.count != '0) begin
                            state_d = HIGH;
                            pulse_d = 1'b1;
                            busy_d  = 1'b1;
                            timer_d = h_in - TIM_W'(1);
                            rem_d   = bus.count;
                            h_d     = h_in;
                            l_d     = l_in;
                        end else begin
                            done_d  = 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TIM_W'(1);
                    end else begin
                        state_d = LOW;
                        pulse_d = 1'b0;
                        timer_d = l_q - TIM_W'(1);
                        rem_d   = rem_q - CNT_W'(1);
                    end
                end
                LOW: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TIM_W'(1);
                    end else if (rem_q == '0) begin
                        // Final low phase has fully elapsed: report completion.
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = HIGH;
                        pulse_d = 1'b1;
                        timer_d = h_q - TIM_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = rem_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench: expected per-cycle waveforms are generated from the
// train parameters (N pulses of H high / L low) and compared at negedges.
module tb_pulse_train_gen;
    localparam int CNT_W = 16;
    localparam int TIM_W = 16;

    typedef struct packed {
        logic             pulse;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] rem;
    } obs_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    obs_t exp_q[$];
    obs_t obs;

    pulse_train_if #(.CNT_W(CNT_W), .TIM_W(TIM_W)) bus ();

    pulse_train_gen #(.CNT_W(CNT_W), .TIM_W(TIM_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.pulse = bus.pulse_out;
        o.busy  = bus.busy;
        o.done  = bus.done;
        o.rem   = bus.remaining;
        return o;
    endfunction

    // Expected outputs for each cycle after the start edge, ending with the done cycle.
    function automatic void build(input int n, input int h, input int l);
        obs_t e;
        int he = (h == 0) ? 1 : h;
        int le = (l == 0) ? 1 : l;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < he; c++) begin
                e = '{pulse: 1'b1, busy: 1'b1, done: 1'b0, rem: CNT_W'(n - k)};
                exp_q.push_back(e);
            end
            for (int c = 0; c < le; c++) begin
                e = '{pulse: 1'b0, busy: 1'b1, done: 1'b0, rem: CNT_W'(n - k - 1)};
                exp_q.push_back(e);
            end
        end
        e = '{pulse: 1'b0, busy: 1'b0, done: 1'b1, rem: '0};
        exp_q.push_back(e);
    endfunction

    function automatic void idle(input int cycles);
        for (int c = 0; c < cycles; c++) exp_q.push_back(obs_t'(0));
    endfunction

    task automatic load(input int n, input int h, input int l);
        bus.count       = CNT_W'(n);
        bus.high_cycles = TIM_W'(h);
        bus.low_cycles  = TIM_W'(l);
        bus.start       = 1'b1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.count = '0; bus.high_cycles = '0; bus.low_cycles = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        obs = sample();
        n_checks++;
        if (obs !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_state got %h want %h", obs, obs_t'(0));
        end
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        int rises = 0, busy_cycles = 0;
        logic prev = 1'b0;
        exp_q.delete(); build(3, 2, 3); idle(2);
        @(negedge clk); load(3, 2, 3);
        foreach (exp_q[i]) begin
            @(negedge clk);
            bus.start = 1'b0;
            obs = sample();
            if (obs.pulse && !prev) rises++;
            prev = obs.pulse;
            if (obs.busy) busy_cycles++;
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic cyc%0d got %h want %h", i, obs, exp_q[i]);
            end
        end
        n_checks++;
        if (rises !== 3) begin
            n_fail++;
            $display("FAIL basic_rises got %0d want 3", rises);
        end
        n_checks++;
        if (busy_cycles !== 15) begin
            n_fail++;
            $display("FAIL basic_busy got %0d want 15", busy_cycles);
        end
    endtask

    task automatic test_clamp();
        exp_q.delete(); build(4, 0, 0); idle(1);
        @(negedge clk); load(4, 0, 0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            bus.start = 1'b0;
            obs = sample();
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL clamp cyc%0d got %h want %h", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_count();
        exp_q.delete(); build(0, 3, 3); idle(3);
        @(negedge clk); load(0, 3, 3);
        foreach (exp_q[i]) begin
            @(negedge clk);
            bus.start = 1'b0;
            obs = sample();
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL zero_count cyc%0d got %h want %h", i, obs, exp_q[i]);
            end
        end
    endtask

    // Mid-train start/parameter changes are ignored; start in the done cycle chains a new train.
    task automatic test_back_to_back();
        int dones = 0;
        exp_q.delete(); build(5, 1, 1); build(2, 3, 1); idle(2);
        @(negedge clk); load(5, 1, 1);
        foreach (exp_q[i]) begin
            @(negedge clk);
            bus.start = (i == 2 || i == 10);
            if (i == 2) begin
                bus.count = CNT_W'(2);
                bus.high_cycles = TIM_W'(3);
            end
            obs = sample();
            if (obs.done) dones++;
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d got %h want %h", i, obs, exp_q[i]);
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (dones !== 2) begin
            n_fail++;
            $display("FAIL back_to_back_dones got %0d want 2", dones);
        end
    endtask

    task automatic test_abort();
        exp_q.delete(); build(10, 4, 4);
        @(negedge clk); load(10, 4, 4);
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = (i == 25);
            obs = sample();
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL abort_pre cyc%0d got %h want %h", i, obs, exp_q[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.abort = 1'b0;
            obs = sample();
            n_checks++;
            if (obs !== obs_t'(0)) begin
                n_fail++;
                $display("FAIL abort_post cyc%0d got %h want %h", i, obs, obs_t'(0));
            end
        end
        exp_q.delete(); build(2, 1, 2); idle(1);
        @(negedge clk); load(2, 1, 2);
        foreach (exp_q[i]) begin
            @(negedge clk);
            bus.start = 1'b0;
            obs = sample();
            n_checks++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL abort_restart cyc%0d got %h want %h", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); load(3, 5, 2);
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        resetn = 1'b0;
        #1;
        obs = sample();
        n_checks++;
        if (obs !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_async got %h want %h", obs, obs_t'(0));
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            obs = sample();
            n_checks++;
            if (obs !== obs_t'(0)) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d got %h want %h", i, obs, obs_t'(0));
            end
        end
    endtask

    task automatic test_random();
        int n, h, l;
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(0, 6);
            h = $urandom_range(0, 5);
            l = $urandom_range(0, 5);
            exp_q.delete(); build(n, h, l); idle(2);
            @(negedge clk); load(n, h, l);
            foreach (exp_q[i]) begin
                @(negedge clk);
                bus.start = 1'b0;
                bus.high_cycles = TIM_W'($urandom_range(0, 7));
                obs = sample();
                n_checks++;
                if (obs !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random t%0d n%0d h%0d l%0d cyc%0d got %h want %h",
                             t, n, h, l, i, obs, exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_zero_count();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Generates a programmable train of digital pulses on `pulse_out`. It is the source side of the motor feedback sensor line.
- Uses: emulating a hall/encoder sensor into the position counter during bring-up and in benches, or driving step-type actuators.
- Software or an upstream FSM loads pulse count, high time and low time, then strikes `start`. The block reports `busy`/`done` and the number of pulses still outstanding.

Parameters:
- CNT_W, 16, width of pulse-count input and `remaining` output
- TIM_W, 16, width of high/low phase duration inputs (in clk cycles)

Ports:
- clk  input  1  system clock; all logic on rising edge
- resetn  input  1  asynchronous active-low reset
- start  input  1  begin a train; sampled only in IDLE
- abort  input  1  terminate current train immediately
- count  input  CNT_W  number of pulses to emit
- high_cycles  input  TIM_W  pulse high duration in clk cycles (0 treated as 1)
- low_cycles  input  TIM_W  pulse low duration in clk cycles (0 treated as 1)
- pulse_out  output  1  generated sensor/pulse signal, registered
- busy  output  1  high while a train is in progress
- done  output  1  one-cycle strobe on normal completion
- remaining  output  CNT_W  pulses not yet completed (decrements at each high-to-low transition)

Behaviour:
- Reset (asynchronous, `resetn` low): `state`=IDLE, `pulse_out`=0, `busy`=0, `done`=0, `remaining`=0, internal timer=0, latched H/L=0. Reset mid-train aborts the train with no `done`.
- Effective durations: H = max(`high_cycles`,1), L = max(`low_cycles`,1). Both are latched at start; input changes while busy have no effect.
- FSM states: IDLE, HIGH, LOW. `done` defaults to 0 every cycle unless set below.
- IDLE, `start`=1, `abort`=0, `count`!=0, at edge T: state<=HIGH, `pulse_out`<=1, `busy`<=1, timer<=H-1, `remaining`<=`count`.
- IDLE, `start`=1, `count`==0: `done`<=1 for one cycle. `busy` and `pulse_out` stay 0, no pulses.
- HIGH: if timer!=0, timer--. If timer==0: state<=LOW, `pulse_out`<=0, timer<=L-1, `remaining`<=`remaining`-1.
- LOW: if timer!=0, timer--. If timer==0:
  - `remaining`==0: state<=IDLE, `busy`<=0, `done`<=1.
  - otherwise: state<=HIGH, `pulse_out`<=1, timer<=H-1.
- Timing results:
  - `pulse_out` is high exactly H cycles and low exactly L cycles per pulse; period is H+L.
  - `busy` is high exactly N*(H+L) cycles, with its first high cycle coinciding with the first high cycle of `pulse_out`.
  - `done` asserts in the first cycle after the last low phase, the same cycle `busy` falls. The final low phase is always emitted.
- `start` while busy: ignored, no restart, no queueing.
- `start` in the same cycle `done` is high (state already IDLE): accepted normally, giving back-to-back trains.
- `abort` (any state, synchronous): state<=IDLE, `pulse_out`<=0, `busy`<=0, `remaining`<=0, no `done`. `abort` takes priority over `start` in the same cycle.
- Arithmetic:
  - Timer and counters are unsigned.
  - `remaining` never underflows, because it is decremented only in HIGH and HIGH is entered only with `remaining`>=1.
  - Max count 2^CNT_W-1; max duration 2^TIM_W-1 cycles per phase.

Test Plan:
- Basic train, `count`=3, H=2, L=3, one `start` pulse:
  - `pulse_out` = 1,1,0,0,0 repeated 3 times.
  - `busy` high 15 cycles; `done` high on cycle 16 for 1 cycle.
  - `remaining` goes 3→2→1→0 at each falling edge.
  - A rising-edge counter attached to `pulse_out` reads 3.
- Zero-duration clamp, `count`=4, `high_cycles`=0, `low_cycles`=0:
  - `pulse_out` = 1,0,1,0,1,0,1,0.
  - `busy` high 8 cycles, then `done`.
- Zero count, `count`=0 with `start`:
  - `done` high exactly 1 cycle after the start edge.
  - `busy` and `pulse_out` never assert.
- Ignored inputs while busy, `count`=5, H=1, L=1:
  - `start` re-asserted and `count`/`high_cycles` changed mid-train have no effect.
  - Exactly 5 pulses at period 2, one `done`.
  - `start` in the `done` cycle launches a second train immediately.
- Abort mid-train, `count`=10, H=4, L=4, `abort` after 3 full pulses plus 2 high cycles:
  - `pulse_out`, `busy`, `remaining` are 0 the next cycle; no `done`.
  - A subsequent `start` works normally.
- Reset mid-train:
  - `resetn` low during a HIGH phase forces all outputs to 0 asynchronously, before the next clock edge.
  - After release the block stays IDLE until `start`.
